mips_run_ctrl: RTL and testbench

MIPS_RUN_CTRL -- requirements
Module: mips_run_ctrl

---
 rtl/mips_run_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_mips_run_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl: test sequencer for a MIPS core. Streams a program into
// instruction memory, holds the core in reset, releases it for a fixed number
// of cycles, then optionally compares the register file with expected values.
// Optional feature macro: MIPS_RUN_CTRL_CHECK_EN builds the CHECK state and the
// register comparison; without it a finished run reports pass immediately.
module mips_run_ctrl #(
    parameter int DATA_W     = 32,
    parameter int IMEM_DEPTH = 1024,
    parameter int REG_NUM    = 32,
    parameter int CYC_W      = 16,
    parameter int RST_CYC    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [CYC_W-1:0]              instr_num,
    input  logic                          ld_valid,
    output logic                          ld_ready,
    input  logic [DATA_W-1:0]             ld_data,
    input  logic                          ld_last,
    output logic                          imem_we,
    output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    output logic [DATA_W-1:0]             imem_wdata,
    output logic                          core_rst,
    output logic [$clog2(REG_NUM)-1:0]    reg_addr,
    input  logic [DATA_W-1:0]             reg_data,
    input  logic                          chk_valid,
    output logic                          chk_ready,
    input  logic [DATA_W-1:0]             chk_data,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic [7:0]                    err_cnt,
    output logic [$clog2(REG_NUM)-1:0]    fail_reg
);

    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int RW = $clog2(REG_NUM);

`ifdef MIPS_RUN_CTRL_CHECK_EN
    localparam logic HAS_CHECK = 1'b1;
`else
    localparam logic HAS_CHECK = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CRST,
        RUN,
        CHECK,
        DONE
    } state_t;

    state_t           r_state;
    logic [AW-1:0]    r_addr;
    logic [CYC_W-1:0] r_cnt;
    logic [CYC_W-1:0] r_instr;
    logic             r_ld_ready;
    logic             r_core_rst;
    logic [RW-1:0]    r_reg_addr;
    logic             r_chk_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [7:0]       r_err_cnt;
    logic [RW-1:0]    r_fail_reg;

    logic             w_ld_fire;
    logic             w_load_end;
    logic             w_crst_end;
    logic             w_run_end;
    logic             w_instr_zero;
    state_t           w_post_state;

    assign w_ld_fire    = ld_valid & r_ld_ready;
    assign w_load_end   = ld_last | (r_addr == AW'(IMEM_DEPTH - 1));
    assign w_crst_end   = (r_cnt == CYC_W'(RST_CYC - 1));
    assign w_run_end    = (r_cnt == (r_instr - CYC_W'(1)));
    assign w_instr_zero = (r_instr == '0);
    // Where a finished run goes: register check when built in, else report.
    assign w_post_state = HAS_CHECK ? CHECK : DONE;

`ifdef MIPS_RUN_CTRL_CHECK_EN
    logic       w_chk_fire;
    logic       w_mismatch;
    logic       w_last_reg;
    logic [7:0] w_err_nxt;

    assign w_chk_fire = chk_valid & r_chk_ready;
    assign w_mismatch = (reg_data != chk_data);
    assign w_last_reg = (r_reg_addr == RW'(REG_NUM - 1));
    assign w_err_nxt  = (w_chk_fire && w_mismatch && (r_err_cnt != 8'hFF))
                        ? r_err_cnt + 8'd1 : r_err_cnt;
`else
    logic w_unused_chk;
    assign w_unused_chk = chk_valid ^ (^chk_data) ^ (^reg_data);
`endif

    // Sequencer: state, counters and all registered handshake/status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_instr     <= '0;
            r_ld_ready  <= 1'b0;
            r_core_rst  <= 1'b1;
            r_reg_addr  <= '0;
            r_chk_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_cnt   <= '0;
            r_fail_reg  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_instr    <= instr_num;
                        r_err_cnt  <= '0;
                        r_pass     <= 1'b0;
                        r_fail_reg <= '0;
                        r_addr     <= '0;
                        r_reg_addr <= '0;
                        r_ld_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (w_ld_fire) begin
                        r_addr <= r_addr + AW'(1);
                        if (w_load_end) begin
                            r_ld_ready <= 1'b0;
                            r_cnt      <= '0;
                            r_state    <= CRST;
                        end
                    end
                end
                CRST: begin
                    if (!w_crst_end) begin
                        r_cnt <= r_cnt + CYC_W'(1);
                    end else if (!w_instr_zero) begin
                        r_core_rst <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= RUN;
                    end else begin
                        // Zero-length run: skip RUN so core_rst never drops.
                        r_chk_ready <= HAS_CHECK;
                        r_done      <= ~HAS_CHECK;
                        r_pass      <= ~HAS_CHECK;
                        r_state     <= w_post_state;
                    end
                end
                RUN: begin
                    if (!w_run_end) begin
                        r_cnt <= r_cnt + CYC_W'(1);
                    end else begin
                        r_core_rst  <= 1'b1;
                        r_chk_ready <= HAS_CHECK;
                        r_done      <= ~HAS_CHECK;
                        r_pass      <= ~HAS_CHECK;
                        r_state     <= w_post_state;
                    end
                end
                CHECK: begin
`ifdef MIPS_RUN_CTRL_CHECK_EN
                    if (w_chk_fire) begin
                        r_err_cnt <= w_err_nxt;
                        if (w_mismatch && (r_err_cnt == 8'd0)) begin
                            r_fail_reg <= r_reg_addr;
                        end
                        if (w_last_reg) begin
                            r_chk_ready <= 1'b0;
                            r_reg_addr  <= '0;
                            r_done      <= 1'b1;
                            r_pass      <= (w_err_nxt == 8'd0);
                            r_state     <= DONE;
                        end else begin
                            r_reg_addr <= r_reg_addr + RW'(1);
                        end
                    end
`else
                    r_state <= IDLE;
`endif
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ld_ready   = r_ld_ready;
    assign imem_we    = w_ld_fire;
    assign imem_addr  = r_addr;
    assign imem_wdata = ld_data;
    assign core_rst   = r_core_rst;
    assign reg_addr   = r_reg_addr;
    assign chk_ready  = r_chk_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_cnt    = r_err_cnt;
    assign fail_reg   = r_fail_reg;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// tb_mips_run_ctrl: directed self-checking bench for mips_run_ctrl.
// Inputs change 1 time unit after the falling edge; a monitor records DUT
// activity 3 time units after the falling edge.
module tb_mips_run_ctrl;

    localparam int DATA_W     = 32;
    localparam int IMEM_DEPTH = 1024;
    localparam int REG_NUM    = 32;
    localparam int CYC_W      = 16;
    localparam int RST_CYC    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CYC_W-1:0]  instr_num;
    logic              ld_valid;
    logic              ld_ready;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              imem_we;
    logic [9:0]        imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              core_rst;
    logic [4:0]        reg_addr;
    logic [DATA_W-1:0] reg_data;
    logic              chk_valid;
    logic              chk_ready;
    logic [DATA_W-1:0] chk_data;
    logic              busy;
    logic              done;
    logic              pass;
    logic [7:0]        err_cnt;
    logic [4:0]        fail_reg;

    always #5 clk = ~clk;

    mips_run_ctrl #(
        .DATA_W(DATA_W), .IMEM_DEPTH(IMEM_DEPTH), .REG_NUM(REG_NUM),
        .CYC_W(CYC_W), .RST_CYC(RST_CYC)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .instr_num(instr_num),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .ld_last(ld_last), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_rst(core_rst), .reg_addr(reg_addr),
        .reg_data(reg_data), .chk_valid(chk_valid), .chk_ready(chk_ready),
        .chk_data(chk_data), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .fail_reg(fail_reg)
    );

    // Register-file model: fixed contents per index
    function automatic logic [31:0] rf_val(input logic [4:0] a);
        return 32'h5A00_0000 + 32'(a) * 32'd17;
    endfunction

    function automatic logic [31:0] word_val(input int unsigned i);
        return 32'hA500_0000 + i;
    endfunction

    always_comb reg_data = rf_val(reg_addr);

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Monitor state
    int unsigned cyc = 0;
    int unsigned n_we, n_run, n_done, n_chk_rdy;
    int unsigned last_we_cyc, first_run_cyc, last_run_cyc, done_cyc, first_chk_cyc;
    int unsigned tot_chk_rdy = 0, tot_raddr_nz = 0;
    logic        done_pass;
    logic [7:0]  done_err;
    logic [4:0]  done_fail;
    int unsigned wa_q[$];
    logic [31:0] wd_q[$];

    always @(negedge clk) begin
        #3;
        cyc++;
        if (imem_we) begin
            n_we++;
            wa_q.push_back(32'(imem_addr));
            wd_q.push_back(imem_wdata);
            last_we_cyc = cyc;
        end
        if (!core_rst) begin
            if (n_run == 0) first_run_cyc = cyc;
            n_run++;
            last_run_cyc = cyc;
        end
        if (done) begin
            n_done++;
            done_cyc  = cyc;
            done_pass = pass;
            done_err  = err_cnt;
            done_fail = fail_reg;
        end
        if (chk_ready) begin
            if (n_chk_rdy == 0) first_chk_cyc = cyc;
            n_chk_rdy++;
            tot_chk_rdy++;
        end
        if (reg_addr != 5'd0) tot_raddr_nz++;
    end

    task automatic clr_mon();
        n_we = 0; n_run = 0; n_done = 0; n_chk_rdy = 0;
        last_we_cyc = 0; first_run_cyc = 0; last_run_cyc = 0;
        done_cyc = 0; first_chk_cyc = 0;
        done_pass = 1'bx; done_err = 'x; done_fail = 'x;
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b0; start = 1'b0; instr_num = '0; ld_valid = 1'b0;
        ld_data = '0; ld_last = 1'b0; chk_valid = 1'b0; chk_data = '0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        clr_mon();
    endtask

    task automatic do_start(input int unsigned n);
        tick();
        start = 1'b1;
        instr_num = CYC_W'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic load_words(input int unsigned n, input bit last_on);
        int unsigned i = 0;
        int unsigned tries = 0;
        while (i < n && tries < n + 20) begin
            tick();
            ld_valid = 1'b1;
            ld_data  = word_val(i);
            ld_last  = last_on && (i == n - 1);
            tries++;
            if (ld_ready) i++;
        end
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

`ifdef MIPS_RUN_CTRL_CHECK_EN
    task automatic feed_check(input bit bad);
        for (int unsigned k = 0; k < 64; k++) begin
            if (chk_ready) break;
            tick();
        end
        check_eq("chk_ready_wait", 32'(chk_ready), 32'd1);
        if (chk_ready) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                if (i == 12) begin
                    chk_valid = 1'b0;
                    chk_data  = '1;
                    tick();
                end
                chk_valid = 1'b1;
                chk_data  = rf_val(5'(i)) ^ ((bad && (i == 5 || i == 9)) ? 32'h10 : 32'h0);
                tick();
            end
            chk_valid = 1'b0;
        end
    endtask
`endif

    task automatic wait_done(input int unsigned budget);
        for (int unsigned k = 0; k < budget; k++) begin
            if (n_done != 0) break;
            tick();
        end
    endtask

    task automatic finish_test();
`ifdef MIPS_RUN_CTRL_CHECK_EN
        feed_check(1'b0);
`endif
        wait_done(100);
        tick(); tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; instr_num = '0; ld_valid = 1'b0;
        ld_data = '0; ld_last = 1'b0; chk_valid = 1'b0; chk_data = '0;
        clr_mon();

        // Reset values, imem_we gated even with ld_valid high
        tick();
        rst = 1'b0;
        ld_valid = 1'b1;
        #1;
        check_eq("rst_core_rst", 32'(core_rst), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_pass", 32'(pass), 32'd0);
        check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
        check_eq("rst_fail_reg", 32'(fail_reg), 32'd0);
        check_eq("rst_reg_addr", 32'(reg_addr), 32'd0);
        check_eq("rst_ld_ready", 32'(ld_ready), 32'd0);
        check_eq("rst_chk_ready", 32'(chk_ready), 32'd0);
        check_eq("rst_imem_we", 32'(imem_we), 32'd0);
        ld_valid = 1'b0;

        // Load three words and run two cycles
        do_reset();
        do_start(2);
        check_eq("t1_busy", 32'(busy), 32'd1);
        load_words(3, 1'b1);
        finish_test();
        check_eq("t1_n_we", n_we, 32'd3);
        check_eq("t1_addr0", wa_q[0], 32'd0);
        check_eq("t1_addr1", wa_q[1], 32'd1);
        check_eq("t1_addr2", wa_q[2], 32'd2);
        check_eq("t1_data2", wd_q[2], 32'hA500_0002);
        check_eq("t1_n_run", n_run, 32'd2);
        check_eq("t1_crst_gap", first_run_cyc - last_we_cyc, 32'd5);
        check_eq("t1_n_done", n_done, 32'd1);
        check_eq("t1_pass", 32'(done_pass), 32'd1);
        check_eq("t1_err", 32'(done_err), 32'd0);
        check_eq("t1_busy_after", 32'(busy), 32'd0);
`ifdef MIPS_RUN_CTRL_CHECK_EN
        check_eq("t1_chk_gap", first_chk_cyc - last_run_cyc, 32'd1);
        check_eq("t1_chk_len", n_chk_rdy, 32'd33);

        // Mismatches at registers 5 and 9
        do_reset();
        do_start(2);
        load_words(4, 1'b1);
        feed_check(1'b1);
        wait_done(50);
        tick(); tick();
        check_eq("t2_n_done", n_done, 32'd1);
        check_eq("t2_err", 32'(done_err), 32'd2);
        check_eq("t2_fail_reg", 32'(done_fail), 32'd5);
        check_eq("t2_pass", 32'(done_pass), 32'd0);
        check_eq("t2_err_held", 32'(err_cnt), 32'd2);
        check_eq("t2_fail_held", 32'(fail_reg), 32'd5);
`else
        check_eq("t1_done_gap", done_cyc - last_run_cyc, 32'd1);
`endif

        // Zero-cycle run
        do_reset();
        do_start(0);
        load_words(2, 1'b1);
        finish_test();
        check_eq("t3_n_we", n_we, 32'd2);
        check_eq("t3_n_run", n_run, 32'd0);
        check_eq("t3_n_done", n_done, 32'd1);
        check_eq("t3_pass", 32'(done_pass), 32'd1);
`ifdef MIPS_RUN_CTRL_CHECK_EN
        check_eq("t3_chk_gap", first_chk_cyc - last_we_cyc, 32'd5);
`else
        check_eq("t3_done_gap", done_cyc - last_we_cyc, 32'd5);
`endif

        // Pass held until next start; start during LOAD is ignored
        check_eq("t5_pass_held", 32'(pass), 32'd1);
        clr_mon();
        do_start(1);
        check_eq("t5_pass_clr", 32'(pass), 32'd0);
        ld_valid = 1'b1; ld_data = word_val(0); ld_last = 1'b0;
        tick();
        ld_valid = 1'b0; start = 1'b1; instr_num = 16'd7;
        tick();
        start = 1'b0; ld_valid = 1'b1; ld_data = word_val(1); ld_last = 1'b1;
        check_eq("t5_busy", 32'(busy), 32'd1);
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        finish_test();
        check_eq("t5_n_we", n_we, 32'd2);
        check_eq("t5_addr1", wa_q[1], 32'd1);
        check_eq("t5_n_run", n_run, 32'd1);
        check_eq("t5_n_done", n_done, 32'd1);

        // Reset asserted during RUN
        do_reset();
        do_start(10);
        load_words(1, 1'b1);
        for (int unsigned k = 0; k < 20; k++) begin
            if (!core_rst) break;
            tick();
        end
        check_eq("t4_run_entered", 32'(core_rst), 32'd0);
        tick(); tick();
        rst = 1'b0;
        #1;
        check_eq("t4_core_rst", 32'(core_rst), 32'd1);
        check_eq("t4_busy", 32'(busy), 32'd0);
        check_eq("t4_done", 32'(done), 32'd0);
        tick(); tick();
        rst = 1'b1;
        for (int unsigned k = 0; k < 30; k++) tick();
        check_eq("t4_n_run", n_run, 32'd2);
        check_eq("t4_no_done", n_done, 32'd0);
        check_eq("t4_idle_busy", 32'(busy), 32'd0);
        check_eq("t4_idle_core_rst", 32'(core_rst), 32'd1);

        // Full-depth load without ld_last
        do_reset();
        do_start(1);
        load_words(IMEM_DEPTH, 1'b0);
        tick();
        ld_valid = 1'b1;
        ld_data  = 32'hDEAD_BEEF;
        #1;
        check_eq("t6_ld_ready_after", 32'(ld_ready), 32'd0);
        check_eq("t6_we_after", 32'(imem_we), 32'd0);
        ld_valid = 1'b0;
        finish_test();
        check_eq("t6_n_we", n_we, 32'd1024);
        check_eq("t6_first_addr", wa_q[0], 32'd0);
        check_eq("t6_last_addr", wa_q[1023], 32'd1023);
        check_eq("t6_last_data", wd_q[1023], 32'hA500_03FF);
        check_eq("t6_n_done", n_done, 32'd1);

`ifndef MIPS_RUN_CTRL_CHECK_EN
        // No-check build: done one cycle after RUN, checker outputs idle
        do_reset();
        do_start(5);
        load_words(1, 1'b1);
        finish_test();
        check_eq("t7_n_run", n_run, 32'd5);
        check_eq("t7_done_gap", done_cyc - last_run_cyc, 32'd1);
        check_eq("t7_pass", 32'(done_pass), 32'd1);
        check_eq("t7_err", 32'(done_err), 32'd0);
        check_eq("t7_chk_ready_never", tot_chk_rdy, 32'd0);
        check_eq("t7_reg_addr_zero", tot_raddr_nz, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1);
    end

endmodule
